// File: rtl/itf_pad_if.sv
// itf_pad_if: bundles the GIC-side word channels and the pad-side beat
// channels of itf_pad.
//   PORT_WIDTH : GIC word width
//   PAD_WIDTH  : off-chip pad beat width
// Modports:
//   slave  : the itf_pad view (consumes GIC words and pad beats, produces
//            pad beats and GIC words)
//   master : the surrounding environment (GIC + pad)
interface itf_pad_if #(
  parameter int PORT_WIDTH = 128,
  parameter int PAD_WIDTH  = 32
);
  // GIC -> interface
  logic                  GICITF_CmdVld;
  logic [PORT_WIDTH-1:0] GICITF_Dat;
  logic                  GICITF_DatVld;
  logic                  GICITF_DatLast;
  logic                  ITFGIC_DatRdy;
  // interface -> GIC
  logic [PORT_WIDTH-1:0] ITFGIC_Dat;
  logic                  ITFGIC_DatVld;
  logic                  ITFGIC_DatLast;
  logic                  GICITF_DatRdy;
  // interface -> pad
  logic [PAD_WIDTH-1:0]  ITFPAD_Dat;
  logic                  ITFPAD_DatVld;
  logic                  ITFPAD_DatLast;
  logic                  ITFPAD_CmdVld;
  logic                  PADITF_DatRdy;
  // pad -> interface
  logic [PAD_WIDTH-1:0]  PADITF_Dat;
  logic                  PADITF_DatVld;
  logic                  PADITF_DatLast;
  logic                  ITFPAD_DatRdy;
  // pad direction
  logic                  ITFPAD_Dir;

  modport slave (
    input  GICITF_CmdVld, GICITF_Dat, GICITF_DatVld, GICITF_DatLast,
    output ITFGIC_DatRdy,
    output ITFGIC_Dat, ITFGIC_DatVld, ITFGIC_DatLast,
    input  GICITF_DatRdy,
    output ITFPAD_Dat, ITFPAD_DatVld, ITFPAD_DatLast, ITFPAD_CmdVld,
    input  PADITF_DatRdy,
    input  PADITF_Dat, PADITF_DatVld, PADITF_DatLast,
    output ITFPAD_DatRdy,
    output ITFPAD_Dir
  );

  modport master (
    output GICITF_CmdVld, GICITF_Dat, GICITF_DatVld, GICITF_DatLast,
    input  ITFGIC_DatRdy,
    input  ITFGIC_Dat, ITFGIC_DatVld, ITFGIC_DatLast,
    output GICITF_DatRdy,
    input  ITFPAD_Dat, ITFPAD_DatVld, ITFPAD_DatLast, ITFPAD_CmdVld,
    output PADITF_DatRdy,
    output PADITF_Dat, PADITF_DatVld, PADITF_DatLast,
    input  ITFPAD_DatRdy,
    input  ITFPAD_Dir
  );
endinterface

// File: rtl/itf_pad.sv
// itf_pad: width converter between the GIC word bus (PORT_WIDTH) and a
// narrow off-chip pad bus (PAD_WIDTH). A transfer starts with a command
// word from the GIC which is serialised onto the pad as command beats;
// bit[0] of the command then selects either GIC->pad data (OUT2OFF,
// words serialised LSB slice first) or pad->GIC data (IN2CHIP, beats
// assembled LSB first into words).
// Ports:
//   clk   : sole clock, rising edge
//   Reset : synchronous, active-high
//   bus   : itf_pad_if.slave, all GIC and pad handshake channels
module itf_pad #(
  parameter int PORT_WIDTH = 128,
  parameter int PAD_WIDTH  = 32   // PORT_WIDTH must be a multiple of this
) (
  input  logic       clk,
  input  logic       Reset,
  itf_pad_if.slave   bus
);

  localparam int RATIO = PORT_WIDTH / PAD_WIDTH;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RATIO - 1);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    OUT2OFF,
    IN2CHIP
  } state_t;

  state_t state;
  state_t stateNext;

  // Words viewed as RATIO slices so the beat counter indexes directly.
  logic [RATIO-1:0][PAD_WIDTH-1:0] cmdReg;
  logic [RATIO-1:0][PAD_WIDTH-1:0] outBuf;
  logic [RATIO-1:0][PAD_WIDTH-1:0] inWord;
  logic                            outFull;
  logic                            outLast;
  logic                            wordFull;
  logic                            inLast;
  logic [CNT_W-1:0]                beatCnt;

  logic finalBeat;
  logic padOutHs;
  logic padInHs;
  logic gicInHs;
  logic gicOutHs;
  logic gicRdy;

  // State register
  always_ff @(posedge clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next state and all outputs
  always_comb begin
    stateNext          = state;
    finalBeat          = (beatCnt == LAST_BEAT);
    padOutHs           = 1'b0;
    padInHs            = 1'b0;
    gicInHs            = 1'b0;
    gicOutHs           = 1'b0;
    gicRdy             = 1'b0;
    bus.ITFGIC_DatRdy  = 1'b0;
    bus.ITFGIC_Dat     = '0;
    bus.ITFGIC_DatVld  = 1'b0;
    bus.ITFGIC_DatLast = 1'b0;
    bus.ITFPAD_Dat     = '0;
    bus.ITFPAD_DatVld  = 1'b0;
    bus.ITFPAD_DatLast = 1'b0;
    bus.ITFPAD_CmdVld  = 1'b0;
    bus.ITFPAD_DatRdy  = 1'b0;
    bus.ITFPAD_Dir     = 1'b0;

    unique case (state)
      IDLE: begin
        // Data words without a command are accepted and dropped here.
        gicRdy = 1'b1;
        if (bus.GICITF_CmdVld && bus.GICITF_DatVld) begin
          stateNext = CMD;
        end
      end

      CMD: begin
        bus.ITFPAD_Dir     = 1'b1;
        bus.ITFPAD_CmdVld  = 1'b1;
        bus.ITFPAD_DatVld  = 1'b1;
        bus.ITFPAD_Dat     = cmdReg[beatCnt];
        bus.ITFPAD_DatLast = finalBeat;
        padOutHs           = bus.PADITF_DatRdy;
        if (padOutHs && finalBeat) begin
          stateNext = cmdReg[0][0] ? OUT2OFF : IN2CHIP;
        end
      end

      OUT2OFF: begin
        bus.ITFPAD_Dir    = 1'b1;
        bus.ITFPAD_DatVld = outFull;
        padOutHs          = outFull && bus.PADITF_DatRdy;
        if (outFull) begin
          bus.ITFPAD_Dat     = outBuf[beatCnt];
          bus.ITFPAD_DatLast = outLast && finalBeat;
        end
        // Refill in the same cycle the last slice leaves, so consecutive
        // words go out without a bubble.
        gicRdy  = !outFull || (padOutHs && finalBeat);
        gicInHs = bus.GICITF_DatVld && gicRdy;
        if (padOutHs && finalBeat && outLast) begin
          stateNext = IDLE;
        end
      end

      IN2CHIP: begin
        bus.ITFPAD_DatRdy = !wordFull;
        padInHs           = bus.PADITF_DatVld && !wordFull;
        bus.ITFGIC_DatVld = wordFull;
        if (wordFull) begin
          bus.ITFGIC_Dat     = inWord;
          bus.ITFGIC_DatLast = inLast;
        end
        gicOutHs = wordFull && bus.GICITF_DatRdy;
        if (gicOutHs && inLast) begin
          stateNext = IDLE;
        end
      end

      default: begin
        stateNext = IDLE;
      end
    endcase

    bus.ITFGIC_DatRdy = gicRdy;
  end

  // Datapath: command register, outgoing buffer, incoming assembly
  always_ff @(posedge clk) begin
    if (Reset) begin
      cmdReg   <= '0;
      outBuf   <= '0;
      inWord   <= '0;
      outFull  <= 1'b0;
      outLast  <= 1'b0;
      wordFull <= 1'b0;
      inLast   <= 1'b0;
      beatCnt  <= '0;
    end else if (stateNext != state) begin
      // Every state change starts the next phase from an empty slate;
      // a word accepted on the final OUT2OFF beat is dropped here.
      beatCnt  <= '0;
      outFull  <= 1'b0;
      outLast  <= 1'b0;
      wordFull <= 1'b0;
      inLast   <= 1'b0;
      if (state == IDLE) begin
        cmdReg <= bus.GICITF_Dat;
      end
    end else begin
      unique case (state)
        CMD: begin
          if (padOutHs) begin
            beatCnt <= beatCnt + 1'b1;
          end
        end

        OUT2OFF: begin
          if (padOutHs) begin
            beatCnt <= finalBeat ? '0 : beatCnt + 1'b1;
          end
          if (gicInHs) begin
            outBuf  <= bus.GICITF_Dat;
            outFull <= 1'b1;
            outLast <= bus.GICITF_DatLast;
          end else if (padOutHs && finalBeat) begin
            outFull <= 1'b0;
          end
        end

        IN2CHIP: begin
          if (padInHs) begin
            // Clearing on the first slice leaves unfilled upper slices
            // zero when the pad ends a word early.
            if (beatCnt == '0) begin
              inWord <= '0;
            end
            inWord[beatCnt] <= bus.PADITF_Dat;
            if (finalBeat || bus.PADITF_DatLast) begin
              wordFull <= 1'b1;
              inLast   <= bus.PADITF_DatLast;
              beatCnt  <= '0;
            end else begin
              beatCnt <= beatCnt + 1'b1;
            end
          end
          if (gicOutHs) begin
            wordFull <= 1'b0;
          end
        end

        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_itf_pad.sv
// tb_itf_pad: directed testbench for itf_pad. A transaction-level model
// (queues of expected pad beats and GIC words) is filled by the stimulus
// and checked by one compare process on every falling clock edge.
module tb_itf_pad;

  localparam int PW = 128;
  localparam int BW = 32;
  localparam int R  = PW / BW;

  typedef struct {
    logic [BW-1:0] d;
    logic          cmd;
    logic          last;
  } padBeat_t;

  typedef struct {
    logic [PW-1:0] d;
    logic          last;
  } gicWord_t;

  logic clk;
  logic Reset;
  int   errors;
  int   checks;
  int   cyc;
  bit   armed;

  padBeat_t padExp[$];
  gicWord_t gicExp[$];
  int       outBeatCyc[$];

  itf_pad_if #(.PORT_WIDTH(PW), .PAD_WIDTH(BW)) bus ();

  itf_pad #(.PORT_WIDTH(PW), .PAD_WIDTH(BW)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected completion", name);
  endtask

  // ---------------- model ----------------
  function automatic void modelCmd(input logic [PW-1:0] c);
    for (int i = 0; i < R; i++)
      padExp.push_back(padBeat_t'{d: c[i*BW +: BW], cmd: 1'b1, last: (i == R-1)});
  endfunction

  function automatic void modelOut(input logic [PW-1:0] w, input logic l);
    for (int i = 0; i < R; i++)
      padExp.push_back(padBeat_t'{d: w[i*BW +: BW], cmd: 1'b0, last: l && (i == R-1)});
  endfunction

  // Pad beats are mult*(b+1); last on beat n.
  function automatic void modelIn(input int n, input logic [BW-1:0] mult);
    logic [PW-1:0] w;
    w = '0;
    for (int b = 0; b < n; b++) begin
      w[(b % R)*BW +: BW] = mult * BW'(b + 1);
      if ((b % R) == R-1 || b == n-1) begin
        gicExp.push_back(gicWord_t'{d: w, last: (b == n-1)});
        w = '0;
      end
    end
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (armed) begin
      if (bus.ITFPAD_DatVld) begin
        if (padExp.size() == 0) begin
          chk("pad_unexpected_beat", PW'(bus.ITFPAD_DatVld), '0);
        end else begin
          chk("pad_dat", PW'(bus.ITFPAD_Dat), PW'(padExp[0].d));
          chk("pad_cmdvld", PW'(bus.ITFPAD_CmdVld), PW'(padExp[0].cmd));
          chk("pad_last", PW'(bus.ITFPAD_DatLast), PW'(padExp[0].last));
          chk("pad_dir", PW'(bus.ITFPAD_Dir), PW'(1'b1));
          if (bus.PADITF_DatRdy) begin
            if (!padExp[0].cmd) outBeatCyc.push_back(cyc);
            void'(padExp.pop_front());
          end
        end
      end else begin
        chk("pad_dat_zero", PW'(bus.ITFPAD_Dat), '0);
        chk("pad_cmd_idle", PW'(bus.ITFPAD_CmdVld), '0);
      end

      if (bus.ITFGIC_DatVld) begin
        if (gicExp.size() == 0) begin
          chk("gic_unexpected_word", PW'(bus.ITFGIC_DatVld), '0);
        end else begin
          chk("gic_dat", bus.ITFGIC_Dat, gicExp[0].d);
          chk("gic_last", PW'(bus.ITFGIC_DatLast), PW'(gicExp[0].last));
          chk("pad_rdy_while_full", PW'(bus.ITFPAD_DatRdy), '0);
          if (bus.GICITF_DatRdy) void'(gicExp.pop_front());
        end
      end else begin
        chk("gic_dat_zero", bus.ITFGIC_Dat, '0);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic gicSend(input logic [PW-1:0] d, input logic c, input logic l);
    int  n;
    bit  done;
    n    = 0;
    done = 0;
    bus.GICITF_Dat     = d;
    bus.GICITF_CmdVld  = c;
    bus.GICITF_DatLast = l;
    bus.GICITF_DatVld  = 1'b1;
    while (!done) begin
      @(negedge clk);
      done = bus.ITFGIC_DatRdy;
      @(posedge clk); #1;
      n++;
      if (!done && n > 50) begin
        failNow("gic_send");
        done = 1;
      end
    end
  endtask

  task automatic gicIdle();
    bus.GICITF_DatVld  = 1'b0;
    bus.GICITF_CmdVld  = 1'b0;
    bus.GICITF_DatLast = 1'b0;
    bus.GICITF_Dat     = '0;
  endtask

  task automatic padSend(input logic [BW-1:0] d, input logic l);
    int n;
    bit done;
    n    = 0;
    done = 0;
    bus.PADITF_Dat     = d;
    bus.PADITF_DatLast = l;
    bus.PADITF_DatVld  = 1'b1;
    while (!done) begin
      @(negedge clk);
      done = bus.ITFPAD_DatRdy;
      @(posedge clk); #1;
      n++;
      if (!done && n > 50) begin
        failNow("pad_send");
        done = 1;
      end
    end
    bus.PADITF_DatVld  = 1'b0;
    bus.PADITF_DatLast = 1'b0;
    bus.PADITF_Dat     = '0;
  endtask

  task automatic waitDrained(input string name);
    int n;
    n = 0;
    while ((padExp.size() != 0 || gicExp.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) failNow(name);
  endtask

  task automatic chkIdle(input string name);
    @(negedge clk);
    chk({name, "_gicrdy"}, PW'(bus.ITFGIC_DatRdy), PW'(1'b1));
    chk({name, "_padvld"}, PW'(bus.ITFPAD_DatVld), '0);
    chk({name, "_dir"}, PW'(bus.ITFPAD_Dir), '0);
    chk({name, "_padrdy"}, PW'(bus.ITFPAD_DatRdy), '0);
    chk({name, "_gicvld"}, PW'(bus.ITFGIC_DatVld), '0);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  logic [PW-1:0] cmdOut;
  logic [PW-1:0] cmdIn;
  logic [PW-1:0] w0;
  logic [PW-1:0] w1;

  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;
    armed  = 0;
    Reset  = 1'b1;
    gicIdle();
    bus.GICITF_DatRdy  = 1'b1;
    bus.PADITF_DatRdy  = 1'b1;
    bus.PADITF_Dat     = '0;
    bus.PADITF_DatVld  = 1'b0;
    bus.PADITF_DatLast = 1'b0;
    cmdOut = (PW'(16'h0002) << 33) | (PW'(32'h89AB_CDEF) << 1) | PW'(1);
    cmdIn  = PW'(128'h2A);
    w0     = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
    w1     = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;

    repeat (2) @(posedge clk);
    #1;
    Reset = 1'b0;
    armed = 1;
    chkIdle("reset");

    // Data word without a command in IDLE is dropped
    gicSend(128'hDEAD_BEEF, 1'b0, 1'b0);
    gicIdle();
    repeat (2) @(posedge clk);
    #1;
    chkIdle("idle_discard");

    // Command to OUT2OFF, then two words, second last
    modelCmd(cmdOut);
    chk("model_cmd_beat0", PW'(padExp[0].d), PW'(32'h1357_9BDF));
    chk("model_cmd_beat1", PW'(padExp[1].d), PW'(32'h0000_0005));
    gicSend(cmdOut, 1'b1, 1'b0);
    gicIdle();
    waitDrained("cmd_out_beats");
    @(negedge clk);
    chk("out2off_dir", PW'(bus.ITFPAD_Dir), PW'(1'b1));
    chk("out2off_gicrdy", PW'(bus.ITFGIC_DatRdy), PW'(1'b1));
    chk("out2off_padvld", PW'(bus.ITFPAD_DatVld), '0);
    @(posedge clk); #1;

    outBeatCyc.delete();
    modelOut(w0, 1'b0);
    modelOut(w1, 1'b1);
    chk("model_out_beat0", PW'(padExp[0].d), PW'(32'hA0A0_A0A0));
    chk("model_out_last", PW'(padExp[7].last), PW'(1'b1));
    gicSend(w0, 1'b0, 1'b0);
    gicSend(w1, 1'b0, 1'b1);
    gicIdle();
    waitDrained("out_beats");
    chk("out_beat_count", PW'(outBeatCyc.size()), PW'(8));
    if (outBeatCyc.size() == 8)
      chk("out_no_bubble", PW'(outBeatCyc[7] - outBeatCyc[0]), PW'(7));
    chkIdle("out_done");

    // IN2CHIP: 8 beats 1..8
    modelCmd(cmdIn);
    gicSend(cmdIn, 1'b1, 1'b0);
    gicIdle();
    waitDrained("cmd_in_beats");
    modelIn(8, 32'd1);
    chk("model_in8_w0", gicExp[0].d, 128'h00000004_00000003_00000002_00000001);
    chk("model_in8_w1", gicExp[1].d, 128'h00000008_00000007_00000006_00000005);
    for (int b = 1; b <= 8; b++) padSend(BW'(b), b == 8);
    waitDrained("in8_words");
    chkIdle("in8_done");

    // IN2CHIP: 6 beats, short final word
    modelCmd(cmdIn);
    gicSend(cmdIn, 1'b1, 1'b0);
    gicIdle();
    waitDrained("cmd_in6_beats");
    modelIn(6, 32'd1);
    chk("model_in6_w1", gicExp[1].d, 128'h00000000_00000000_00000006_00000005);
    chk("model_in6_last", PW'(gicExp[1].last), PW'(1'b1));
    for (int b = 1; b <= 6; b++) padSend(BW'(b), b == 6);
    waitDrained("in6_words");
    chkIdle("in6_done");

    // IN2CHIP with GIC back-pressure for 5 cycles
    modelCmd(cmdIn);
    gicSend(cmdIn, 1'b1, 1'b0);
    gicIdle();
    waitDrained("cmd_stall_beats");
    bus.GICITF_DatRdy = 1'b0;
    modelIn(5, 32'h11);
    for (int b = 1; b <= 4; b++) padSend(BW'(b * 32'h11), 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_padrdy", PW'(bus.ITFPAD_DatRdy), '0);
      chk("stall_gicvld", PW'(bus.ITFGIC_DatVld), PW'(1'b1));
      chk("stall_word", bus.ITFGIC_Dat, 128'h00000044_00000033_00000022_00000011);
      @(posedge clk); #1;
    end
    bus.GICITF_DatRdy = 1'b1;
    padSend(32'h55, 1'b1);
    waitDrained("stall_words");
    chkIdle("stall_done");

    // Reset while the second beat of an OUT2OFF word is on the pad
    modelCmd(cmdOut);
    gicSend(cmdOut, 1'b1, 1'b0);
    gicIdle();
    waitDrained("cmd_rst_beats");
    modelOut(w0, 1'b0);
    gicSend(w0, 1'b0, 1'b0);
    gicIdle();
    @(posedge clk); #1;
    Reset = 1'b1;
    @(posedge clk); #1;
    Reset = 1'b0;
    padExp.delete();
    chkIdle("mid_reset");
    repeat (6) @(posedge clk);
    #1;
    chkIdle("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
